// File: rtl/mcs8_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mcs8_bus_ctrl
//
// Bus-cycle controller for the MCS-8 CPU. It sits between the CPU's
// multiplexed data/state/sync pins and the memory/IO devices.
// - The low address byte is latched in T1.
// - The high address bits and the cycle type are latched in T2.
// - The address is decoded into N_REGION parametrised regions.
// - Read, write and IO strobes are generated, and wait states are inserted
//   per region through READY_O.
// - Unmapped accesses and writes to read-only regions set a sticky bus-error
//   flag.
//
// Ports
//   CLK_I     in   CLK2 phase clock; all registers update on its rising edge
//   nRST_I    in   asynchronous active-low reset
//   STATE_I   in   [2:0] CPU state code (T1=010 T2=100 T3=001 T4=111 T5=101
//                  TW=000 T1I=110 STOP=011)
//   SYNC_I    in   CPU SYNC; T1/T2/T3 only latch while it is high
//   DAT_I     in   [7:0] CPU data-out bus
//   CLR_I     in   clears BUSERR_O on the next edge (a set event wins)
//   ADDR_O    out  [13:0] latched address
//   CYC_O     out  [1:0] latched cycle type (PCI=00 PCC=01 PCR=10 PCW=11)
//   CS_O      out  [N_REGION-1:0] one-hot region select, zero on miss/PCC
//   RD_O      out  read enable for PCI/PCR cycles that hit a region
//   IO_O      out  IO cycle indicator (PCC)
//   WR_O      out  one-cycle write strobe after a PCW T3
//   WDATA_O   out  [7:0] latched write data
//   READY_O   out  READY to the CPU
//   BUSERR_O  out  sticky bus-error flag
//
// Handshake: READY_O is a level, not a pulse.
// - It drops on the T2 edge that selects a region with a nonzero wait count.
// - It rises again on the TW edge that takes the wait counter from 1 to 0.
// - The CPU keeps issuing TW states while it samples READY_O low.
// - STOP states neither advance nor disturb the count.
// ---------------------------------------------------------------------------
module mcs8_bus_ctrl #(
  parameter int                        N_REGION    = 2,
  parameter logic [N_REGION*14-1:0]    REGION_BASE = {14'h2000, 14'h0000},
  parameter logic [N_REGION*14-1:0]    REGION_MASK = {14'h3C00, 14'h2000},
  parameter logic [N_REGION*4-1:0]     REGION_WAIT = {4'd0, 4'd0},
  parameter logic [N_REGION-1:0]       REGION_RO   = 2'b01
) (
  input  logic                CLK_I,
  input  logic                nRST_I,
  input  logic [2:0]          STATE_I,
  input  logic                SYNC_I,
  input  logic [7:0]          DAT_I,
  input  logic                CLR_I,
  output logic [13:0]         ADDR_O,
  output logic [1:0]          CYC_O,
  output logic [N_REGION-1:0] CS_O,
  output logic                RD_O,
  output logic                IO_O,
  output logic                WR_O,
  output logic [7:0]          WDATA_O,
  output logic                READY_O,
  output logic                BUSERR_O
);

  localparam logic [2:0] ST_T1 = 3'b010;
  localparam logic [2:0] ST_T2 = 3'b100;
  localparam logic [2:0] ST_T3 = 3'b001;
  localparam logic [2:0] ST_TW = 3'b000;

  localparam logic [1:0] CYC_PCI = 2'b00;
  localparam logic [1:0] CYC_PCC = 2'b01;
  localparam logic [1:0] CYC_PCR = 2'b10;
  localparam logic [1:0] CYC_PCW = 2'b11;

  logic                t1_latch;
  logic                t2_latch;
  logic                t3_write;
  logic                tw_edge;

  logic [13:0]         dec_addr;
  logic [1:0]          dec_cyc;
  logic                dec_pcc;
  logic [N_REGION-1:0] dec_cs;
  logic                dec_hit;
  logic                dec_ro;
  logic [3:0]          dec_wait;

  logic [3:0]          wait_cnt;
  logic                hit_ro_q;   // selected region is read-only
  logic                cur_hit;
  logic                err_set;

  assign t1_latch = SYNC_I && (STATE_I == ST_T1);
  assign t2_latch = SYNC_I && (STATE_I == ST_T2);
  assign t3_write = SYNC_I && (STATE_I == ST_T3) && (CYC_O == CYC_PCW);
  assign tw_edge  = (STATE_I == ST_TW);

  // Decode the address being completed on this T2 edge, not the stale one.
  assign dec_addr = {DAT_I[5:0], ADDR_O[7:0]};
  assign dec_cyc  = DAT_I[7:6];
  assign dec_pcc  = (dec_cyc == CYC_PCC);

  // Lowest-indexed matching region wins; PCC cycles never select a region.
  always_comb begin
    dec_cs   = '0;
    dec_hit  = 1'b0;
    dec_ro   = 1'b0;
    dec_wait = 4'd0;
    for (int i = 0; i < N_REGION; i++) begin
      if (!dec_hit && !dec_pcc &&
          ((dec_addr & REGION_MASK[i*14 +: 14]) == REGION_BASE[i*14 +: 14])) begin
        dec_hit   = 1'b1;
        dec_cs[i] = 1'b1;
        dec_ro    = REGION_RO[i];
        dec_wait  = REGION_WAIT[i*4 +: 4];
      end
    end
  end

  assign cur_hit = |CS_O;
  assign err_set = (t2_latch && !dec_pcc && !dec_hit) ||
                   (t3_write && cur_hit && hit_ro_q);

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      ADDR_O   <= '0;
      CYC_O    <= CYC_PCI;
      CS_O     <= '0;
      RD_O     <= 1'b0;
      IO_O     <= 1'b0;
      WR_O     <= 1'b0;
      WDATA_O  <= '0;
      READY_O  <= 1'b1;
      BUSERR_O <= 1'b0;
      wait_cnt <= 4'd0;
      hit_ro_q <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; only the T3 branch raises it.
      WR_O <= 1'b0;

      if (t1_latch) begin
        ADDR_O[7:0] <= DAT_I;
        CS_O        <= '0;
        RD_O        <= 1'b0;
        IO_O        <= 1'b0;
        hit_ro_q    <= 1'b0;
      end else if (t2_latch) begin
        ADDR_O[13:8] <= DAT_I[5:0];
        CYC_O        <= dec_cyc;
        CS_O         <= dec_cs;
        RD_O         <= dec_hit && ((dec_cyc == CYC_PCI) || (dec_cyc == CYC_PCR));
        IO_O         <= dec_pcc;
        hit_ro_q     <= dec_ro;
        // A reload mid-wait simply restarts with the new region's count.
        wait_cnt     <= dec_wait;
        READY_O      <= (dec_wait == 4'd0);
      end else if (t3_write) begin
        WDATA_O <= DAT_I;
        WR_O    <= cur_hit && !hit_ro_q;
      end else if (tw_edge && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          READY_O <= 1'b1;
        end
      end

      if (err_set) begin
        BUSERR_O <= 1'b1;
      end else if (CLR_I) begin
        BUSERR_O <= 1'b0;
      end
    end
  end

endmodule
